// File: rtl/branch_unit.sv
// Next-PC source for the LEGv8 single-cycle core: decodes B/BL/BR/CBZ/CBNZ/B.cond,
// produces branch target and PC select, holds NZCV, and keeps saturating branch statistics.
module branch_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] reg_data,
  input  logic [3:0]        alu_flags,
  input  logic              set_flags,
  output logic [ADDR_W-1:0] branch_target,
  output logic              pc_src,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  logic is_b, is_bl, is_cbz, is_cbnz, is_bcond, is_br, is_branch;
  logic taken, cond_ok;
  logic [ADDR_W-1:0] off26, off19, pc_plus4;
  logic n_f, z_f, c_f, v_f;

  assign is_b      = (instr[31:26] == 6'b000101);
  assign is_bl     = (instr[31:26] == 6'b100101);
  assign is_cbz    = (instr[31:24] == 8'b10110100);
  assign is_cbnz   = (instr[31:24] == 8'b10110101);
  assign is_bcond  = (instr[31:24] == 8'b01010100);
  assign is_br     = (instr[31:21] == 11'b11010110000);
  assign is_branch = is_b | is_bl | is_cbz | is_cbnz | is_bcond | is_br;

  assign off26    = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
  assign off19    = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
  assign pc_plus4 = pc + ADDR_W'(4);

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (instr[3:0])
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f & !z_f;
      4'h9: cond_ok = !(c_f & !z_f);
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f & (n_f == v_f);
      4'hD: cond_ok = !(!z_f & (n_f == v_f));
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    taken         = 1'b0;
    branch_target = pc_plus4;
    if (is_b || is_bl) begin
      taken         = 1'b1;
      branch_target = pc + off26;
    end else if (is_cbz) begin
      taken         = (reg_data == '0);
      branch_target = pc + off19;
    end else if (is_cbnz) begin
      taken         = (reg_data != '0);
      branch_target = pc + off19;
    end else if (is_bcond) begin
      taken         = cond_ok;
      branch_target = pc + off19;
    end else if (is_br) begin
      taken         = 1'b1;
      branch_target = reg_data;
    end
  end

  assign pc_src    = instr_valid & is_branch & taken;
  assign link_we   = instr_valid & is_bl;
  assign link_data = pc_plus4;

  // B.cond evaluates the registered flags, so a same-cycle set_flags never affects it.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (instr_valid && set_flags) begin
      flags <= alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (instr_valid && is_branch) begin
      if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
      if (taken && (taken_count != '1)) taken_count <= taken_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: driver queues hand-computed expectations,
// a negedge monitor pops and compares against a full-width and a 4-bit-counter instance.
module tb_branch_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] reg_data;
  logic [3:0]  alu_flags;
  logic        set_flags;

  logic [63:0] branch_target, link_data;
  logic        pc_src, link_we;
  logic [3:0]  flags;
  logic [31:0] branch_count, taken_count;

  logic [63:0] s_target, s_link_data;
  logic        s_pc_src, s_link_we;
  logic [3:0]  s_flags;
  logic [3:0]  s_branch_count, s_taken_count;

  branch_unit #(.ADDR_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .reg_data(reg_data), .alu_flags(alu_flags), .set_flags(set_flags),
    .branch_target(branch_target), .pc_src(pc_src), .link_we(link_we),
    .link_data(link_data), .flags(flags), .branch_count(branch_count),
    .taken_count(taken_count)
  );

  branch_unit #(.ADDR_W(64), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .reg_data(reg_data), .alu_flags(alu_flags), .set_flags(set_flags),
    .branch_target(s_target), .pc_src(s_pc_src), .link_we(s_link_we),
    .link_data(s_link_data), .flags(s_flags), .branch_count(s_branch_count),
    .taken_count(s_taken_count)
  );

  typedef struct packed {
    logic        src;
    logic [63:0] tgt;
    logic        lwe;
    logic [63:0] lnk;
    logic [3:0]  fl;
    logic [31:0] bc;
    logic [31:0] tc;
    logic [3:0]  sbc;
    logic [3:0]  stc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_flags = '0;
  logic [31:0] m_bc = '0, m_tc = '0;
  logic [3:0]  m_sbc = '0, m_stc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk({n, ".pc_src"},        {63'd0, pc_src},           {63'd0, e.src});
      chk({n, ".target"},        branch_target,             e.tgt);
      chk({n, ".link_we"},       {63'd0, link_we},          {63'd0, e.lwe});
      chk({n, ".link_data"},     link_data,                 e.lnk);
      chk({n, ".flags"},         {60'd0, flags},            {60'd0, e.fl});
      chk({n, ".branch_count"},  {32'd0, branch_count},     {32'd0, e.bc});
      chk({n, ".taken_count"},   {32'd0, taken_count},      {32'd0, e.tc});
      chk({n, ".s_branch_count"},{60'd0, s_branch_count},   {60'd0, e.sbc});
      chk({n, ".s_taken_count"}, {60'd0, s_taken_count},    {60'd0, e.stc});
    end
  end

  // Drive one instruction (caller is just past a posedge), queue the expectation, advance one cycle.
  task automatic issue(input string nm, input logic v, input logic [31:0] ins,
                       input logic [63:0] p, input logic [63:0] rd,
                       input logic [3:0] alu, input logic sf,
                       input logic is_br, input logic e_src,
                       input logic [63:0] e_tgt, input logic e_lwe);
    exp_t e;
    instr_valid = v; instr = ins; pc = p; reg_data = rd; alu_flags = alu; set_flags = sf;
    e.src = e_src; e.tgt = e_tgt; e.lwe = e_lwe; e.lnk = p + 64'd4;
    e.fl = m_flags; e.bc = m_bc; e.tc = m_tc; e.sbc = m_sbc; e.stc = m_stc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (v) begin
      if (sf) m_flags = alu;
      if (is_br) begin
        if (m_bc != '1) m_bc = m_bc + 32'd1;
        if (m_sbc != '1) m_sbc = m_sbc + 4'd1;
        if (e_src) begin
          if (m_tc != '1) m_tc = m_tc + 32'd1;
          if (m_stc != '1) m_stc = m_stc + 4'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_B_M4  = 32'h17FF_FFFC;
  localparam logic [31:0] I_BL_M4 = 32'h97FF_FFFC;
  localparam logic [31:0] I_B_P4  = 32'h1400_0004;
  localparam logic [31:0] I_CBZ   = 32'hB400_0060;
  localparam logic [31:0] I_CBNZ  = 32'hB500_0060;
  localparam logic [31:0] I_BCOND = 32'h5400_0060;
  localparam logic [31:0] I_BR    = 32'hD61F_0020;
  localparam logic [31:0] I_SUBS  = 32'hEB01_0000;

  initial begin
    logic [3:0]  combos [4];
    logic [15:0] tbl    [4];
    logic [15:0] row;
    combos[0] = 4'b0000; tbl[0] = 16'hD6AA;
    combos[1] = 4'b0100; tbl[1] = 16'hE6A9;
    combos[2] = 4'b1001; tbl[2] = 16'hD65A;
    combos[3] = 4'b0010; tbl[3] = 16'hD5A6;

    reset = 1'b1; instr_valid = 1'b1; instr = I_B_M4; pc = 64'h1000;
    reg_data = '0; alu_flags = 4'hF; set_flags = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue("reset_state", 0, 32'h0, 64'h200, 0, 4'h0, 0, 0, 0, 64'h204, 0);
    issue("b_back",      1, I_B_M4,  64'h1000, 0, 4'h0, 0, 1, 1, 64'h0FF0, 0);
    issue("bl_back",     1, I_BL_M4, 64'h1000, 0, 4'h0, 0, 1, 1, 64'h0FF0, 1);
    issue("after_bl",    0, 32'h0, 64'h200, 0, 4'h0, 0, 0, 0, 64'h204, 0);
    issue("cbz_zero",    1, I_CBZ,  64'h40, 64'd0, 4'h0, 0, 1, 1, 64'h4C, 0);
    issue("cbz_nonzero", 1, I_CBZ,  64'h40, 64'd5, 4'h0, 0, 1, 0, 64'h4C, 0);
    issue("cbnz_taken",  1, I_CBNZ, 64'h40, 64'd5, 4'h0, 0, 1, 1, 64'h4C, 0);
    issue("br",          1, I_BR,   64'h1000, 64'hDEADBEEF, 4'h0, 0, 1, 1, 64'hDEADBEEF, 0);
    issue("b_wrap",      1, I_B_P4, 64'hFFFF_FFFF_FFFF_FFF8, 0, 4'h0, 0, 1, 1, 64'h8, 0);
    issue("bubble_b",    0, I_B_M4,  64'h1000, 0, 4'hF, 1, 1, 0, 64'h0FF0, 0);
    issue("bubble_bl",   0, I_BL_M4, 64'h1000, 0, 4'hF, 1, 1, 0, 64'h0FF0, 0);
    issue("beq_same_cyc",1, I_BCOND, 64'h40, 0, 4'b0100, 1, 1, 0, 64'h4C, 0);
    issue("beq_next_cyc",1, I_BCOND, 64'h40, 0, 4'h0, 0, 1, 1, 64'h4C, 0);
    issue("subs_clear",  1, I_SUBS,  64'h200, 0, 4'b0000, 1, 0, 0, 64'h204, 0);
    issue("subs_z",      1, I_SUBS,  64'h200, 0, 4'b0100, 1, 0, 0, 64'h204, 0);
    issue("beq_after",   1, I_BCOND, 64'h40, 0, 4'h0, 0, 1, 1, 64'h4C, 0);

    for (int k = 0; k < 4; k++) begin
      row = tbl[k];
      issue($sformatf("subs_set_%b", combos[k]), 1, I_SUBS, 64'h200, 0, combos[k], 1, 0, 0, 64'h204, 0);
      for (int unsigned c = 0; c < 16; c++) begin
        issue($sformatf("bcond_%b_%h", combos[k], c[3:0]), 1, I_BCOND | {28'd0, c[3:0]},
              64'h40, 0, 4'h0, 0, 1, row[c], 64'h4C, 0);
      end
    end

    issue("sat_taken_b", 1, I_B_M4, 64'h1000, 0, 4'h0, 0, 1, 1, 64'h0FF0, 0);
    issue("final_state", 0, 32'h0, 64'h200, 0, 4'h0, 0, 0, 0, 64'h204, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
